// File: rtl/spi_master.sv
// SPI mode-0 initiator. Each start request sends one 16-bit frame {addr, rw, data}, MSB first.
// On a read, the last 8 bits are taken from miso through a 2-flop synchronizer.
module spi_master #(
  parameter int CLKDIV = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso,
  output logic [2:0] dbg_state
);
  localparam int DW = $clog2(CLKDIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [DW-1:0] div;
  logic          div_wrap;
  logic [4:0]    bit_idx;
  logic [14:0]   tx_sr;
  logic [7:0]    rx_sr;
  logic          rw_q;
  logic          miso_m, miso_s;

  assign div_wrap  = (div == DIV_LAST);
  assign dbg_state = state;

  // Handshake: start is a level sampled only in IDLE (including the done cycle);
  // busy covers accept up to, but not including, the single-cycle done pulse.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   if (div_wrap) state_d = SHIFT;
      SHIFT:   if (div_wrap && !sclk && bit_idx == 5'd16) state_d = HOLD;
      HOLD:    if (div_wrap) state_d = GAP;
      GAP:     if (div_wrap) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miso_m <= 1'b0;
      miso_s <= 1'b0;
    end else begin
      miso_m <= miso;
      miso_s <= miso_m;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div     <= '0;
      bit_idx <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rw_q    <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) div <= '0;
      else               div <= div_wrap ? '0 : div + 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            rw_q    <= rw;
            tx_sr   <= {addr[5:0], rw, (rw ? 8'h00 : wdata)};
            mosi    <= addr[6];
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            sclk    <= 1'b0;
            bit_idx <= '0;
          end
        end
        SETUP: if (div_wrap) sclk <= 1'b1;
        SHIFT: begin
          if (div_wrap) begin
            if (sclk) begin
              // Falling edge: the vacated bits shift in as zero, so mosi is 0 after the 16th fall.
              sclk    <= 1'b0;
              bit_idx <= bit_idx + 1'b1;
              mosi    <= tx_sr[14];
              tx_sr   <= {tx_sr[13:0], 1'b0};
            end else if (bit_idx == 5'd16) begin
              mosi <= 1'b0;
            end else begin
              sclk <= 1'b1;
              if (rw_q && bit_idx >= 5'd8) rx_sr <= {rx_sr[6:0], miso_s};
            end
          end
        end
        HOLD: if (div_wrap) cs_n <= 1'b1;
        GAP: begin
          if (div_wrap) begin
            done <= 1'b1;
            busy <= 1'b0;
            if (rw_q) rdata <= rx_sr;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: random and directed frames on a CLKDIV=8 instance plus one
// CLKDIV=12 instance, with a behavioural SPI target and a queue-based scoreboard.
module tb_spi_master;
  localparam int C   = 8;
  localparam int C12 = 12;
  localparam int W   = 24;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // CLKDIV=8 instance
  logic       start = 1'b0, rw = 1'b0, miso = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       busy, done, sclk, cs_n, mosi;
  logic [2:0] dbg_state;

  // CLKDIV=12 instance
  logic       start12 = 1'b0, miso12 = 1'b0;
  logic [7:0] rdata12;
  logic       busy12, done12, sclk12, cs_n12, mosi12;
  logic [2:0] dbg_state12;

  spi_master #(.CLKDIV(C)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .dbg_state(dbg_state)
  );

  spi_master #(.CLKDIV(C12)) dut12 (
    .clk(clk), .reset_n(reset_n), .start(start12), .rw(1'b0), .addr(7'h00), .wdata(8'h00),
    .rdata(rdata12), .busy(busy12), .done(done12), .sclk(sclk12), .cs_n(cs_n12), .mosi(mosi12),
    .miso(miso12), .dbg_state(dbg_state12)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural SPI target ----------------
  // Drives data bit 7..0 after falls 8..15 (3 cycles late); random noise otherwise.
  logic [7:0] tgt_byte = '0;
  int   tgt_falls = 0;
  int   tgt_dly = 0;
  logic tgt_val = 1'b0;
  logic t_prev_sclk = 1'b0;
  always @(negedge clk) begin
    if (cs_n) begin
      tgt_falls = 0;
      tgt_dly = 0;
      miso = 1'($urandom);
    end else if (t_prev_sclk && !sclk) begin
      tgt_falls++;
      tgt_dly = 3;
      tgt_val = (tgt_falls >= 8 && tgt_falls <= 15) ? tgt_byte[15 - tgt_falls] : 1'($urandom);
    end else if (tgt_dly > 0) begin
      tgt_dly--;
      if (tgt_dly == 0) miso = tgt_val;
    end
    t_prev_sclk = sclk;
    miso12 = 1'($urandom);
  end

  // ---------------- scoreboard / monitor (CLKDIV=8) ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  logic [7:0]   model_rdata = '0;
  int fall_hist[$];
  int done_hist[$];
  int pushed = 0, started = 0;
  int fall_c = 0, rises = 0, last_mchg = 0;
  logic [15:0] word = '0;
  logic p_sclk = 1'b0, p_cs = 1'b1, p_mosi = 1'b0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (p_cs && !cs_n) begin
        started++;
        fall_c = cyc;
        rises = 0;
        word = '0;
        last_mchg = cyc;
        fall_hist.push_back(cyc);
        check("frame_requested", 32'(started <= pushed), 32'd1);
        check("busy_at_cs_fall", 32'(busy), 32'd1);
      end
      if (mosi !== p_mosi) last_mchg = cyc;
      if (!p_sclk && sclk) begin
        rises++;
        word = {word[14:0], mosi};
        check("rise_in_cs", 32'(cs_n), 32'd0);
        check("rise_time", cyc - fall_c, C * (2 * rises - 1));
        check("mosi_setup", 32'((cyc - last_mchg) >= C), 32'd1);
      end
      if (!p_cs && cs_n) begin
        check("cs_low_len", cyc - fall_c, 34 * C);
        check("rise_count", rises, 16);
      end
      if (done) begin
        check("done_busy", 32'(busy), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("mosi_word", 32'(word), 32'(e[23:8]));
          check("rdata", 32'(rdata), 32'(e[7:0]));
          check("done_time", cyc - fall_c, 35 * C);
          done_hist.push_back(cyc);
        end
      end
    end
    p_sclk = sclk;
    p_cs = cs_n;
    p_mosi = mosi;
  end

  // ---------------- monitor (CLKDIV=12) ----------------
  logic [7:0] exp12_q[$];
  logic q_sclk = 1'b0, q_cs = 1'b1, mosi_hi12 = 1'b0;
  int f12 = 0, e12 = 0, edges12 = 0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (mosi12) mosi_hi12 = 1'b1;
      if (q_cs && !cs_n12) begin
        f12 = cyc;
        e12 = cyc;
        edges12 = 0;
        mosi_hi12 = mosi12;
      end
      if (q_sclk !== sclk12) begin
        edges12++;
        check("half_period12", cyc - e12, C12);
        e12 = cyc;
      end
      if (!q_cs && cs_n12) begin
        check("cs_low12", cyc - f12, 34 * C12);
        check("edges12", edges12, 32);
        check("mosi_zero12", 32'(mosi_hi12), 32'd0);
      end
      if (done12) begin
        if (exp12_q.size() == 0) check("unexpected_done12", 32'(done12), 32'd0);
        else check("rdata12", 32'(rdata12), 32'(exp12_q.pop_front()));
      end
    end
    q_sclk = sclk12;
    q_cs = cs_n12;
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic rwv, input logic [6:0] a, input logic [7:0] d, input logic [7:0] rb);
    tgt_byte = rb;
    if (rwv) model_rdata = rb;
    exp_q.push_back({a, rwv, (rwv ? 8'h00 : d), model_rdata});
    pushed++;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_done(output int dc);
    int n = 0;
    dc = -1;
    @(negedge clk);
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
    else dc = cyc;
  endtask

  task automatic frame8(input logic rwv, input logic [6:0] a, input logic [7:0] d,
                        input logic [7:0] rb, output int acc);
    wait_idle();
    issue(rwv, a, d, rb);
    start = 1'b1;
    rw = rwv;
    addr = a;
    wdata = d;
    acc = cyc;
    @(negedge clk);
    start = 1'b0;
    rw = 1'($urandom);
    addr = 7'($urandom);
    wdata = 8'($urandom);
  endtask

  task automatic run_frame(input logic rwv, input logic [6:0] a, input logic [7:0] d, input logic [7:0] rb);
    int acc, dc;
    frame8(rwv, a, d, rb, acc);
    wait_done(dc);
    if (dc >= 0) check("done_latency", dc - acc, 1 + 35 * C);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc, dc, da, db, n;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_cs_n12", 32'(cs_n12), 32'd1);
    reset_n = 1'b1;

    run_frame(1'b0, 7'h15, 8'hA5, 8'h00);
    run_frame(1'b1, 7'h7F, 8'hFF, 8'h3C);

    // start during a frame is ignored
    frame8(1'b0, 7'h2A, 8'h5B, 8'h00, acc);
    while (cyc < acc + 50) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(dc);
    if (dc >= 0) check("done_latency_ign", dc - acc, 1 + 35 * C);
    repeat (20) @(negedge clk);
    check("no_second_frame", 32'(cs_n), 32'd1);

    // start held through done: second frame begins in the done cycle
    wait_idle();
    issue(1'b0, 7'h33, 8'h96, 8'h00);
    start = 1'b1;
    rw = 1'b0;
    addr = 7'h33;
    wdata = 8'h96;
    @(negedge clk);
    issue(1'b1, 7'h4C, 8'h00, 8'hC3);
    rw = 1'b1;
    addr = 7'h4C;
    wdata = 8'($urandom);
    wait_done(da);
    @(negedge clk);
    check("b2b_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(db);
    if (da >= 0 && db >= 0) check("b2b_cs_fall", fall_hist[fall_hist.size() - 1], da + 1);

    // reset during bit 9 of a read
    frame8(1'b1, 7'($urandom), 8'h00, 8'h5A, acc);
    repeat (19 * C + 3) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_cs_n", 32'(cs_n), 32'd1);
    check("mid_rst_sclk", 32'(sclk), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rdata", 32'(rdata), 32'd0);
    check("mid_rst_mosi", 32'(mosi), 32'd0);
    void'(exp_q.pop_back());
    model_rdata = 8'h00;
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    run_frame(1'b0, 7'h01, 8'h80, 8'h00);
    run_frame(1'b1, 7'h40, 8'h00, 8'h81);

    // randomized frames
    for (int i = 0; i < 8; i++)
      run_frame(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));

    // CLKDIV=12: write 0x00 to 0x00
    @(negedge clk);
    exp12_q.push_back(rdata12);
    start12 = 1'b1;
    acc = cyc;
    @(negedge clk);
    start12 = 1'b0;
    n = 0;
    while (!done12 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!done12) check("done12_timeout", 32'(done12), 32'd1);
    else check("done_latency12", cyc - acc, 1 + 35 * C12);

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("exp12_q_drained", exp12_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
